neuron_fire_unit: RTL and testbench
===================================

Name: neuron_fire_unit

Overview:
- Downstream consumer of the positive/negative spike-count ripple counters in the ASPEN neuron datapath.
- Gates and clears the counters, then samples both counts at the end of each integration window once the ripple chains have settled.
- Folds the signed difference into a saturating membrane potential with optional leak.
- Compares against a threshold and emits an output spike over a valid/ready handshake.

Parameters:
size_code, 8, width of each input count (matches counter width)
POT_W, 12, width of signed membrane potential and threshold
SETTLE_CYC, 2, cycles (>=1) waited after counting stops before sampling ripple counts
LEAK_SHIFT, 3, leak amount = potential >>> LEAK_SHIFT (arithmetic)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
window_end  input  1  one-cycle pulse: integration window finished
count_pos  input  size_code  unsigned excitatory count from positive counter
count_neg  input  size_code  unsigned inhibitory count from negative counter
threshold  input  POT_W  signed firing threshold, sampled in UPDATE
leak_en  input  1  apply leak in UPDATE
count_enable  output  1  counters may count; high only in COUNT
counter_clear  output  1  active-high clear to both counters; high only in CLEAR
spike_valid  output  1  output spike pending
spike_ready  input  1  downstream accepts spike
potential  output  POT_W  signed membrane potential register
busy  output  1  high in any state other than COUNT
overrun  output  1  sticky: window_end arrived outside COUNT

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- States: COUNT, SETTLE, CAPTURE, UPDATE, FIRE, CLEAR. All outputs are decoded from registered state or registers only; no combinational input-to-output paths.
- Reset values: state=CLEAR, potential=0, spike_valid=0, overrun=0, settle counter=0, capture registers=0.
  - While reset is high: counter_clear=1, count_enable=0, busy=1.
- CLEAR: 1 cycle, then COUNT.
- COUNT: count_enable=1. On window_end=1, go to SETTLE and load the settle counter with SETTLE_CYC-1.
- SETTLE: count_enable=0. Decrement the counter; leave for CAPTURE when it reaches 0. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- CAPTURE: register count_pos and count_neg, then go to UPDATE.
- UPDATE, 1 cycle. Arithmetic:
  - diff = zext(pos) - zext(neg), signed width size_code+1.
  - leaked = leak_en ? potential - (potential >>> LEAK_SHIFT) : potential.
  - sum = leaked + sext(diff), computed at POT_W+1 bits, then saturated to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - If sum >= threshold (signed): potential <= 0, spike_valid <= 1, next state FIRE.
  - Otherwise: potential <= sum, next state CLEAR.
- FIRE: hold spike_valid=1 and keep counters disabled until spike_ready=1. On the handshake cycle, spike_valid <= 0 and go to CLEAR. If spike_ready is already high on entry, FIRE lasts 1 cycle.
- Latency:
  - With window_end sampled at edge E0, potential and spike_valid update at edge E0+SETTLE_CYC+2.
  - Minimum window-to-window turnaround is SETTLE_CYC+3 cycles without a spike, and SETTLE_CYC+4 with an immediately accepted spike.
- overrun: set when window_end=1 in any state other than COUNT; cleared only by reset. That window_end is otherwise ignored.
- Simultaneous events: window_end in the same cycle as the transition CLEAR->COUNT is an overrun, because the state is still CLEAR when it is sampled.
- Reset mid-operation: asserting reset in any state returns to the reset values immediately (asynchronously). A pending spike is discarded.
- threshold and leak_en are sampled only in UPDATE; changes in other states have no effect.

Test Plan:
- Reset/startup: hold reset 3 cycles -> counter_clear=1, count_enable=0, potential=0, busy=1. First cycle after release counter_clear=1; next cycle count_enable=1, busy=0.
- Accumulate then fire (threshold=40, leak_en=0):
  - Window 1, pos=20 neg=5 -> potential=15, no spike.
  - Window 2, pos=30 neg=0 -> sum 45 >= 40, potential=0, spike_valid rises exactly 4 cycles after the window_end edge.
- Negative saturation (POT_W=12, threshold=100):
  - Preload via windows to -2000.
  - pos=0 neg=255 -> potential=-2048.
  - Repeat -> stays -2048, no spike.
- Leak (LEAK_SHIFT=3, potential=80, pos=neg=0, leak_en=1) -> potential=70; same window with leak_en=0 -> 70 unchanged.
- Backpressure/overrun: fire with spike_ready=0 for 5 cycles -> spike_valid, busy stay 1 and count_enable stays 0.
  - window_end pulsed during the hold -> overrun=1.
  - spike_ready=1 -> spike_valid drops next edge, CLEAR pulse, COUNT resumes; overrun still 1.
- Reset in FIRE with spike_valid=1 -> spike_valid=0, potential=0, overrun=0, counter_clear=1 while reset is high.

Source files
------------

// File: rtl/neuron_fire_unit.sv
// Integrate-and-fire control for the ASPEN neuron: gates/clears the spike-count ripple counters,
// samples them after settling, updates a saturating leaky membrane potential and emits spikes.
module neuron_fire_unit #(
    parameter int unsigned size_code  = 8,
    parameter int unsigned POT_W      = 12,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    window_end,
    input  logic [size_code-1:0]    count_pos,
    input  logic [size_code-1:0]    count_neg,
    input  logic signed [POT_W-1:0] threshold,
    input  logic                    leak_en,
    output logic                    count_enable,
    output logic                    counter_clear,
    output logic                    spike_valid,
    input  logic                    spike_ready,
    output logic signed [POT_W-1:0] potential,
    output logic                    busy,
    output logic                    overrun
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        StCount,
        StSettle,
        StCapture,
        StUpdate,
        StFire,
        StClear
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_settle_cnt;
    logic [size_code-1:0]      r_cap_pos;
    logic [size_code-1:0]      r_cap_neg;
    logic signed [POT_W-1:0]   r_potential;
    logic                      r_spike_valid;
    logic                      r_overrun;

    logic signed [size_code:0] w_diff;
    logic signed [POT_W-1:0]   w_leaked;
    logic signed [POT_W:0]     w_sum_wide;
    logic signed [POT_W-1:0]   w_sum;
    logic                      w_fire;

    always_comb begin
        w_diff     = $signed({1'b0, r_cap_pos}) - $signed({1'b0, r_cap_neg});
        w_leaked   = leak_en ? (r_potential - (r_potential >>> LEAK_SHIFT)) : r_potential;
        w_sum_wide = {w_leaked[POT_W-1], w_leaked}
                   + {{(POT_W-size_code){w_diff[size_code]}}, w_diff};
        // Top two bits disagree only when the POT_W-bit result would have wrapped.
        if (w_sum_wide[POT_W] != w_sum_wide[POT_W-1]) begin
            w_sum = w_sum_wide[POT_W] ? POT_MIN : POT_MAX;
        end else begin
            w_sum = w_sum_wide[POT_W-1:0];
        end
        w_fire = (w_sum >= threshold);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StClear:   w_state_nxt = StCount;
            StCount:   if (window_end) w_state_nxt = StSettle;
            StSettle:  if (r_settle_cnt == '0) w_state_nxt = StCapture;
            StCapture: w_state_nxt = StUpdate;
            StUpdate:  w_state_nxt = w_fire ? StFire : StClear;
            StFire:    if (spike_ready) w_state_nxt = StClear;
            default:   w_state_nxt = StClear;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StClear;
            r_settle_cnt  <= '0;
            r_cap_pos     <= '0;
            r_cap_neg     <= '0;
            r_potential   <= '0;
            r_spike_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (window_end && (r_state != StCount)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StCount: begin
                    if (window_end) r_settle_cnt <= SETTLE_LOAD;
                end
                StSettle: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                StCapture: begin
                    r_cap_pos <= count_pos;
                    r_cap_neg <= count_neg;
                end
                StUpdate: begin
                    if (w_fire) begin
                        r_potential   <= '0;
                        r_spike_valid <= 1'b1;
                    end else begin
                        r_potential <= w_sum;
                    end
                end
                StFire: begin
                    if (spike_ready) r_spike_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign count_enable  = (r_state == StCount);
    assign counter_clear = (r_state == StClear);
    assign busy          = (r_state != StCount);
    assign spike_valid   = r_spike_valid;
    assign potential     = r_potential;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_neuron_fire_unit.sv
// Directed and randomized checks of neuron_fire_unit against an integer reference model.
module tb_neuron_fire_unit;

    localparam int SZ     = 8;
    localparam int PW     = 12;
    localparam int SETTLE = 2;
    localparam int LSH    = 3;
    localparam int PMAX   = (1 << (PW - 1)) - 1;
    localparam int PMIN   = -(1 << (PW - 1));

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 window_end = 1'b0;
    logic [SZ-1:0]        count_pos = '0;
    logic [SZ-1:0]        count_neg = '0;
    logic signed [PW-1:0] threshold = '0;
    logic                 leak_en = 1'b0;
    logic                 count_enable;
    logic                 counter_clear;
    logic                 spike_valid;
    logic                 spike_ready = 1'b0;
    logic signed [PW-1:0] potential;
    logic                 busy;
    logic                 overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_p    = 0;
    bit m_fire = 1'b0;
    bit m_ovr  = 1'b0;

    neuron_fire_unit #(
        .size_code (SZ),
        .POT_W     (PW),
        .SETTLE_CYC(SETTLE),
        .LEAK_SHIFT(LSH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .window_end   (window_end),
        .count_pos    (count_pos),
        .count_neg    (count_neg),
        .threshold    (threshold),
        .leak_en      (leak_en),
        .count_enable (count_enable),
        .counter_clear(counter_clear),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .potential    (potential),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: leak, add the count difference, clamp to the potential range, compare.
    task automatic model_update(input int pos, input int neg, input int thr, input bit leak);
        int l;
        int s;
        l = leak ? m_p - (m_p >>> LSH) : m_p;
        s = l + pos - neg;
        if (s > PMAX) s = PMAX;
        if (s < PMIN) s = PMIN;
        m_fire = (s >= thr);
        m_p    = m_fire ? 0 : s;
    endtask

    // Ends at a negedge with the DUT in COUNT.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        window_end  = 1'b0;
        spike_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_clear", counter_clear, 1);
            check("rst_cnt_en", count_enable, 0);
            check("rst_pot", $signed(potential), 0);
            check("rst_busy", busy, 1);
            check("rst_spike", spike_valid, 0);
            check("rst_ovr", overrun, 0);
        end
        reset = 1'b0;
        m_p   = 0;
        m_ovr = 1'b0;
        #1;
        check("rel_clear", counter_clear, 1);
        check("rel_cnt_en", count_enable, 0);
        @(negedge clk);
        check("rel2_cnt_en", count_enable, 1);
        check("rel2_busy", busy, 0);
        check("rel2_clear", counter_clear, 0);
    endtask

    // Starts at a negedge in COUNT; returns at the negedge after the potential update.
    task automatic start_window(input int pos, input int neg, input int thr, input bit leak);
        int old_p;
        old_p       = m_p;
        window_end  = 1'b1;
        count_pos   = pos[SZ-1:0];
        count_neg   = neg[SZ-1:0];
        threshold   = PW'($urandom);
        leak_en     = ~leak;
        @(posedge clk);
        @(negedge clk);
        window_end = 1'b0;
        check("settle_cnt_en", count_enable, 0);
        check("settle_busy", busy, 1);
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        threshold = thr[PW-1:0];
        leak_en   = leak;
        @(posedge clk);
        @(negedge clk);
        count_pos = SZ'($urandom);
        count_neg = SZ'($urandom);
        check("pre_upd_pot", $signed(potential), old_p);
        check("pre_upd_spike", spike_valid, 0);
        model_update(pos, neg, thr, leak);
        @(posedge clk);
        @(negedge clk);
        threshold = PW'($urandom);
        leak_en   = $urandom_range(0, 1);
        check("upd_pot", $signed(potential), m_p);
        check("upd_spike", spike_valid, m_fire);
    endtask

    task automatic finish_window(input int hold, input bit pulse);
        if (m_fire) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_spike", spike_valid, 1);
                check("hold_cnt_en", count_enable, 0);
                check("hold_busy", busy, 1);
                window_end = (pulse && i == 0);
                if (pulse && i == 0) m_ovr = 1'b1;
                @(posedge clk);
                @(negedge clk);
                window_end = 1'b0;
            end
            spike_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            spike_ready = 1'b0;
            check("hs_spike", spike_valid, 0);
            check("hs_clear", counter_clear, 1);
        end else begin
            check("noF_clear", counter_clear, 1);
            check("noF_spike", spike_valid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("resume_cnt_en", count_enable, 1);
        check("resume_busy", busy, 0);
        check("resume_ovr", overrun, m_ovr);
    endtask

    initial begin
        do_reset();

        start_window(20, 5, 40, 0);
        finish_window(0, 0);
        start_window(30, 0, 40, 0);
        check("acc_fire", spike_valid, 1);
        finish_window(0, 0);

        for (int i = 0; i < 7; i++) begin
            start_window(0, 255, 100, 0);
            finish_window(0, 0);
        end
        start_window(0, 215, 100, 0);
        check("preload_m2000", $signed(potential), -2000);
        finish_window(0, 0);
        start_window(0, 255, 100, 0);
        check("sat_neg", $signed(potential), -2048);
        finish_window(0, 0);
        start_window(0, 255, 100, 0);
        check("sat_neg_again", $signed(potential), -2048);
        finish_window(0, 0);

        do_reset();
        start_window(80, 0, 100, 0);
        finish_window(0, 0);
        start_window(0, 0, 100, 1);
        check("leak_70", $signed(potential), 70);
        finish_window(0, 0);
        start_window(0, 0, 100, 0);
        check("noleak_70", $signed(potential), 70);
        finish_window(0, 0);

        start_window(50, 0, 40, 0);
        finish_window(5, 1);
        check("ovr_sticky", overrun, 1);

        // window_end arriving while CLEAR hands over to COUNT is still an overrun.
        do_reset();
        start_window(3, 1, 500, 0);
        window_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        window_end = 1'b0;
        check("clr_edge_ovr", overrun, 1);
        check("clr_edge_counting", count_enable, 1);
        @(posedge clk);
        @(negedge clk);
        check("clr_edge_still_count", count_enable, 1);

        do_reset();
        start_window(200, 0, 10, 0);
        window_end = 1'b1;
        @(posedge clk);
        @(negedge clk);
        window_end = 1'b0;
        check("fire_ovr", overrun, 1);
        check("fire_pending", spike_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_spike", spike_valid, 0);
        check("arst_pot", $signed(potential), 0);
        check("arst_ovr", overrun, 0);
        check("arst_clear", counter_clear, 1);
        do_reset();

        for (int i = 0; i < 60; i++) begin
            start_window($urandom_range(0, 255), $urandom_range(0, 255),
                         int'($urandom_range(0, 600)) - 300, $urandom_range(0, 1));
            finish_window($urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
